// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared widths, grant FSM state type and response-stage record
package mem_bus_pkg;

  localparam int INTG_W = 7;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [0:0] {
    GNT_IDLE = 1'b0,
    GNT_WAIT = 1'b1
  } gnt_state_e;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } resp_stage_t;

endpackage

// File: rtl/mem_bus_intg_gen.sv
// rtl/mem_bus_intg_gen.sv - combinational 32->7 integrity code, bit i = XOR of data bits j with j mod 7 == i
module mem_bus_intg_gen
  import mem_bus_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [INTG_W-1:0] intg_o
);

  for (genvar i = 0; i < INTG_W; i++) begin : g_bit
    logic [DATA_W-1:0] sel;
    for (genvar j = 0; j < DATA_W; j++) begin : g_sel
      assign sel[j] = ((j % INTG_W) == i) ? data_i[j] : 1'b0;
    end
    assign intg_o[i] = ^sel;
  end

endmodule

// File: rtl/mem_bus_resp.sv
// rtl/mem_bus_resp.sv - memory bus responder: grant FSM, backing array, in-order response pipeline
// Optional macro MEM_BUS_INTG_EN enables write-data integrity checking and read-data integrity generation.
module mem_bus_resp
  import mem_bus_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          GNT_DLY   = 0,
  parameter int          RESP_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic [INTG_W-1:0] data_wdata_intg_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic [INTG_W-1:0] data_rdata_intg_o,
  output logic              data_err_o
);

  localparam int         AW      = $clog2(MEM_WORDS);
  localparam int         SW      = $bits(resp_stage_t);
  localparam int         PIPE_W  = RESP_LAT * SW;
  localparam logic [2:0] GNT_CNT = 3'(GNT_DLY);

  gnt_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              gnt;
  logic              accept;
  logic              in_range;
  logic              intg_err;
  logic              acc_err;
  logic              wr_en;
  logic [AW-1:0]     widx;
  logic [DATA_W-1:0] wmask;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  resp_stage_t       new_stage;
  resp_stage_t       out_s;
  logic [PIPE_W-1:0] pipe_q, pipe_d;

  // Grant FSM; with GNT_DLY == 0 the request is granted combinationally and the FSM never leaves IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    if (GNT_DLY == 0) begin
      gnt = data_req_i;
    end else begin
      case (state_q)
        GNT_IDLE: begin
          if (data_req_i) begin
            state_d = GNT_WAIT;
            cnt_d   = 3'd1;
          end
        end
        GNT_WAIT: begin
          if (!data_req_i) begin
            state_d = GNT_IDLE;
            cnt_d   = 3'd0;
          end else if (cnt_q == GNT_CNT) begin
            gnt     = 1'b1;
            state_d = GNT_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = GNT_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  assign data_gnt_o = gnt & ~rst;
  assign accept     = data_req_i & data_gnt_o;

  // BASE_ADDR is aligned to the array size, so the range check is a compare of the upper address bits.
  assign in_range = (data_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign widx     = data_addr_i[AW+1:2];
  assign acc_err  = !in_range || (data_addr_i[1:0] != 2'b00) || intg_err;
  assign wr_en    = accept & data_we_i & ~acc_err;

  for (genvar b = 0; b < BE_W; b++) begin : g_mask
    assign wmask[8*b +: 8] = {8{data_be_i[b]}};
  end

  assign wr_word = (mem_q[widx] & ~wmask) | (data_wdata_i & wmask);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[widx] <= wr_word;
    end
  end

  always_comb begin
    new_stage.valid = accept;
    new_stage.err   = accept & acc_err;
    new_stage.rdata = (accept && !data_we_i && !acc_err) ? mem_q[widx] : '0;
  end

  // Newest response enters at the LSB end; the oldest stage at the MSB end drives the outputs.
  assign pipe_d = PIPE_W'({pipe_q, new_stage});
  assign out_s  = resp_stage_t'(pipe_q[PIPE_W-1 -: SW]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GNT_IDLE;
      cnt_q   <= 3'd0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pipe_q  <= pipe_d;
    end
  end

  assign data_rvalid_o = out_s.valid;
  assign data_err_o    = out_s.valid & out_s.err;
  assign data_rdata_o  = out_s.valid ? out_s.rdata : '0;

`ifdef MEM_BUS_INTG_EN
  logic [INTG_W-1:0] wdata_code;
  logic [INTG_W-1:0] rdata_code;

  mem_bus_intg_gen u_wdata_chk (
    .data_i (data_wdata_i),
    .intg_o (wdata_code)
  );

  mem_bus_intg_gen u_rdata_gen (
    .data_i (data_rdata_o),
    .intg_o (rdata_code)
  );

  assign intg_err          = data_we_i && (wdata_code != data_wdata_intg_i);
  assign data_rdata_intg_o = rdata_code;
`else
  logic unused_wdata_intg;

  assign unused_wdata_intg = ^data_wdata_intg_i;
  assign intg_err          = 1'b0;
  assign data_rdata_intg_o = '0;
`endif

endmodule

// File: tb/tb_mem_bus_resp.sv
// tb/tb_mem_bus_resp.sv - directed table-driven bench for mem_bus_resp (three parameter sets)
module tb_mem_bus_resp;

`ifdef MEM_BUS_INTG_EN
  localparam bit INTG_ON = 1'b1;
`else
  localparam bit INTG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  int   n_tests = 0;
  int   n_fail  = 0;

  // a_: GNT_DLY=0 RESP_LAT=1, b_: GNT_DLY=3 RESP_LAT=1, c_: GNT_DLY=0 RESP_LAT=3
  logic a_req, a_gnt, a_rvalid, a_we, a_err;
  logic [3:0] a_be;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [6:0] a_wintg, a_rintg;
  logic b_req, b_gnt, b_rvalid, b_we, b_err;
  logic [3:0] b_be;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [6:0] b_wintg, b_rintg;
  logic c_req, c_gnt, c_rvalid, c_we, c_err;
  logic [3:0] c_be;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [6:0] c_wintg, c_rintg;

  mem_bus_resp #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DLY(0), .RESP_LAT(1)) u_a (
    .clk(clk), .rst(rst), .data_req_i(a_req), .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid),
    .data_we_i(a_we), .data_be_i(a_be), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
    .data_wdata_intg_i(a_wintg), .data_rdata_o(a_rdata), .data_rdata_intg_o(a_rintg), .data_err_o(a_err));

  mem_bus_resp #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DLY(3), .RESP_LAT(1)) u_b (
    .clk(clk), .rst(rst), .data_req_i(b_req), .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid),
    .data_we_i(b_we), .data_be_i(b_be), .data_addr_i(b_addr), .data_wdata_i(b_wdata),
    .data_wdata_intg_i(b_wintg), .data_rdata_o(b_rdata), .data_rdata_intg_o(b_rintg), .data_err_o(b_err));

  mem_bus_resp #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .GNT_DLY(0), .RESP_LAT(3)) u_c (
    .clk(clk), .rst(rst2), .data_req_i(c_req), .data_gnt_o(c_gnt), .data_rvalid_o(c_rvalid),
    .data_we_i(c_we), .data_be_i(c_be), .data_addr_i(c_addr), .data_wdata_i(c_wdata),
    .data_wdata_intg_i(c_wintg), .data_rdata_o(c_rdata), .data_rdata_intg_o(c_rintg), .data_err_o(c_err));

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bad_intg;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic logic [6:0] code7(input logic [31:0] d);
    logic [6:0] c;
    c = '0;
    for (int j = 0; j < 32; j++) c[j % 7] = c[j % 7] ^ d[j];
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_c(input string name);
    check({name, " rvalid"}, {31'b0, c_rvalid}, 32'h0);
    check({name, " err"}, {31'b0, c_err}, 32'h0);
    check({name, " rdata"}, c_rdata, 32'h0);
    check({name, " rintg"}, {25'b0, c_rintg}, 32'h0);
  endtask

  logic [31:0] c_exp [8];

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_AA00, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_AAEF};
    vecs[4]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 4'hF, 32'h0000_0011, 32'h0,         1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, 32'h0000_1010, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 4'hF, 32'h0000_0012, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_AAEF};
    vecs[9]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 32'hDEAD_AAEF};
    vecs[11] = '{1'b1, 4'hF, 32'h0000_0FFC, 32'h1122_3344, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 4'h9, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         1'b0, 1'b0, 32'hCA22_330D};
    vecs[14] = '{1'b1, 4'hF, 32'h0000_0020, 32'h0000_007F, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 4'hF, 32'h0000_0020, 32'hFFFF_FFFF, 1'b1, INTG_ON, 32'h0};
    vecs[16] = '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         1'b0, 1'b0,
                 INTG_ON ? 32'h0000_007F : 32'hFFFF_FFFF};
    vecs[17] = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         1'b0, 1'b1, 32'h0};

    a_req = 1'b1; a_we = 1'b0; a_be = 4'hF; a_addr = 32'h10; a_wdata = '0; a_wintg = '0;
    b_req = 1'b0; b_we = 1'b1; b_be = 4'hF; b_addr = 32'h30; b_wdata = 32'h1; b_wintg = code7(32'h1);
    c_req = 1'b0; c_we = 1'b0; c_be = 4'hF; c_addr = 32'h40; c_wdata = '0; c_wintg = '0;
    rst = 1'b1;
    rst2 = 1'b1;

    // Reset state while a request is pending.
    repeat (2) @(negedge clk);
    check("reset gnt", {31'b0, a_gnt}, 32'h0);
    check("reset rvalid", {31'b0, a_rvalid}, 32'h0);
    check("reset err", {31'b0, a_err}, 32'h0);
    check("reset rdata", a_rdata, 32'h0);
    check("reset rintg", {25'b0, a_rintg}, 32'h0);
    a_req = 1'b0;
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    check("idle gnt", {31'b0, a_gnt}, 32'h0);
    check("idle rvalid", {31'b0, a_rvalid}, 32'h0);

    // Back-to-back table vectors on instance a; response of vector i-1 is visible while i is driven.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        a_req   = 1'b1;
        a_we    = vecs[i].we;
        a_be    = vecs[i].be;
        a_addr  = vecs[i].addr;
        a_wdata = vecs[i].wdata;
        a_wintg = vecs[i].bad_intg ? 7'h00 : code7(vecs[i].wdata);
      end else begin
        a_req = 1'b0;
      end
      #1;
      if (i < NV) check($sformatf("v%0d gnt", i), {31'b0, a_gnt}, 32'h1);
      else        check("tail gnt", {31'b0, a_gnt}, 32'h0);
      if (i > 0) begin
        check($sformatf("v%0d rvalid", i-1), {31'b0, a_rvalid}, 32'h1);
        check($sformatf("v%0d err", i-1), {31'b0, a_err}, {31'b0, vecs[i-1].exp_err});
        check($sformatf("v%0d rdata", i-1), a_rdata, vecs[i-1].exp_rdata);
        check($sformatf("v%0d rintg", i-1), {25'b0, a_rintg},
              {25'b0, INTG_ON ? code7(vecs[i-1].exp_rdata) : 7'h00});
      end
      @(negedge clk);
    end
    check("a rvalid after stream", {31'b0, a_rvalid}, 32'h0);

    // Instance b: grant on the 4th cycle of a held request.
    b_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("b held k%0d gnt", k), {31'b0, b_gnt}, {31'b0, k == 4});
      check($sformatf("b held k%0d rvalid", k), {31'b0, b_rvalid}, 32'h0);
      @(negedge clk);
    end
    b_req = 1'b0;
    #1;
    check("b resp rvalid", {31'b0, b_rvalid}, 32'h1);
    check("b resp err", {31'b0, b_err}, 32'h0);
    check("b after grant gnt", {31'b0, b_gnt}, 32'h0);
    @(negedge clk);

    // Request withdrawn after two cycles: no grant, FSM back to IDLE.
    b_req = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      #1;
      check($sformatf("b drop k%0d gnt", k), {31'b0, b_gnt}, 32'h0);
      @(negedge clk);
    end
    b_req = 1'b0;
    #1;
    check("b dropped gnt", {31'b0, b_gnt}, 32'h0);
    check("b dropped rvalid", {31'b0, b_rvalid}, 32'h0);
    @(negedge clk);
    check("b dropped rvalid2", {31'b0, b_rvalid}, 32'h0);

    // A fresh request must again wait the full delay.
    b_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("b rereq k%0d gnt", k), {31'b0, b_gnt}, {31'b0, k == 4});
      @(negedge clk);
    end
    b_req = 1'b0;

    // Instance c: four writes then four reads back-to-back, responses three cycles later.
    for (int m = 0; m < 4; m++) c_exp[m] = 32'h0;
    for (int m = 4; m < 8; m++) c_exp[m] = 32'hA5C3_0000 + 32'(m - 4);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        c_req   = 1'b1;
        c_we    = (k < 4);
        c_addr  = 32'h40 + 32'(4 * (k % 4));
        c_wdata = 32'hA5C3_0000 + 32'(k % 4);
        c_wintg = code7(c_wdata);
      end else begin
        c_req = 1'b0;
      end
      #1;
      if (k >= 3 && k - 3 < 8) begin
        check($sformatf("c k%0d rvalid", k), {31'b0, c_rvalid}, 32'h1);
        check($sformatf("c k%0d err", k), {31'b0, c_err}, 32'h0);
        check($sformatf("c k%0d rdata", k), c_rdata, c_exp[k-3]);
      end else begin
        check($sformatf("c k%0d rvalid", k), {31'b0, c_rvalid}, 32'h0);
      end
      @(negedge clk);
    end

    // Reset mid-stream: in-flight reads are dropped and nothing follows release.
    c_we = 1'b0;
    c_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c_addr = 32'h40 + 32'(4 * k);
      @(negedge clk);
    end
    rst2 = 1'b1;
    #1;
    check_idle_c("c in reset");
    check("c in reset gnt", {31'b0, c_gnt}, 32'h0);
    repeat (2) @(negedge clk);
    check_idle_c("c in reset late");
    c_req = 1'b0;
    rst2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("c post reset k%0d rvalid", k), {31'b0, c_rvalid}, 32'h0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_resp.md
MEM_BUS_RESP -- requirements
Module: mem_bus_resp

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 32-bit words in the backing array (power of two).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0 (aligned to 4*MEM_WORDS).
REQ-003 Parameter GNT_DLY, default 0: cycles a request is held before grant (0..7).
REQ-004 Parameter RESP_LAT, default 1: cycles from acceptance edge to rvalid (1..4).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 data_req_i  input  1  initiator request.
REQ-009 data_gnt_o  output  1  request accepted this cycle when high with data_req_i.
REQ-010 data_rvalid_o  output  1  response valid, one cycle per accepted request.
REQ-011 data_we_i  input  1  1 = write, 0 = read.
REQ-012 data_be_i  input  4  byte enables, bit n covers wdata[8n+7:8n].
REQ-013 data_addr_i  input  32  byte address.
REQ-014 data_wdata_i  input  32  write data.
REQ-015 data_wdata_intg_i  input  7  write-data integrity code.
REQ-016 data_rdata_o  output  32  read data.
REQ-017 data_rdata_intg_o  output  7  read-data integrity code.
REQ-018 data_err_o  output  1  error flag, valid with rvalid.

Function
REQ-019 Grant FSM states: IDLE, WAIT; GNT_DLY=0: gnt = data_req_i combinationally, FSM stays IDLE.
REQ-020 GNT_DLY>0: IDLE + req -> WAIT, counter loaded 1; WAIT increments; gnt high when counter==GNT_DLY and req; then -> IDLE.
REQ-021 req dropping in WAIT -> IDLE, counter cleared, no grant.
REQ-022 Acceptance = data_req_i & data_gnt_o at rising edge; back-to-back acceptances allowed every cycle when GNT_DLY=0.
REQ-023 Error on accept when addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) or addr[1:0]!=0.
REQ-024 Write without error commits on the acceptance edge, only enabled bytes; be=0 is a legal no-op.
REQ-025 Read samples array on acceptance edge; read accepted one cycle after a write to same word returns new data.
REQ-026 Responses in order, rvalid exactly RESP_LAT cycles after acceptance edge; no response backpressure.
REQ-027 Response pipeline: RESP_LAT stages, each {valid, err, rdata}; up to RESP_LAT responses in flight.
REQ-028 data_rdata_o = 0 for writes, errored accesses, and whenever rvalid=0; data_err_o = 0 when rvalid=0.
REQ-029 Errored access leaves array unchanged.

Reset
REQ-030 Reset: gnt, rvalid, err, rdata, rdata_intg = 0; FSM IDLE; counter 0; pipeline valids 0.
REQ-031 Reset mid-operation drops in-flight responses; none issued after reset release.
REQ-032 Array contents not reset.

Configuration
REQ-033 Macro MEM_BUS_INTG_EN defined: rdata_intg_o = code(rdata_o); write with wdata_intg_i != code(wdata_i) -> err=1, no write.
REQ-034 code(d) bit i = XOR of d[j] for all j with j mod 7 == i.
REQ-035 Macro undefined: rdata_intg_o tied 0, wdata_intg_i ignored, no integrity errors.

Structure
REQ-036 Package mem_bus_pkg: INTG_W=7, DATA_W=32, BE_W=4, grant FSM state enum, response-stage struct.
REQ-037 Sub-module mem_bus_intg_gen: combinational 32->7 code of REQ-034, used for check and generate.

Verification
REQ-038 GNT_DLY=0, RESP_LAT=1: write 0xDEADBEEF be=0xF to 0x10, read 0x10 -> gnt same cycle, rvalid next cycle, rdata=0xDEADBEEF, err=0.
REQ-039 Partial write be=0x2 data 0x0000AA00 over 0xDEADBEEF at 0x10 -> later read 0xDEADAAEF.
REQ-040 Read of 0x0000_1000 (MEM_WORDS=1024) and of 0x11 -> rvalid with err=1, rdata=0; array unchanged.
REQ-041 GNT_DLY=3, req held -> gnt on 4th cycle of req; req dropped after 2 cycles -> no gnt, FSM IDLE.
REQ-042 RESP_LAT=3, four back-to-back reads -> four rvalids in consecutive cycles starting 3 cycles after first accept, in order; rst asserted mid-stream -> all outputs 0, no further rvalid.
REQ-043 MEM_BUS_INTG_EN: write 0xFFFFFFFF with wdata_intg=0 -> err=1, no write; read of 0x0000007F returns rdata_intg=0x7F.
